// File: rtl/qspi_stream_fifo_pkg.sv
// Shared definitions for the QSPI prefetch FIFO: stream state encoding and default sizing.
package qspi_stream_fifo_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  localparam int DEF_DEPTH      = 4;
  localparam int DEF_DATA_BYTES = 2;

endpackage

// File: rtl/qspi_stream_fifo_mem.sv
// DEPTH x W register array: one synchronous write port, asynchronous read at the head pointer.
module qspi_stream_fifo_mem #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [DEPTH-1:0][W-1:0] r_mem;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/qspi_stream_fifo.sv
// Prefetch FIFO between the SPI flash controller and a stream consumer; keeps itself topped up
// by issuing start/continue/stop to the controller with at most one fetch outstanding.
module qspi_stream_fifo
  import qspi_stream_fifo_pkg::*;
#(
  parameter int DATA_WIDTH_BYTES = DEF_DATA_BYTES,
  parameter int DEPTH            = DEF_DEPTH,
  parameter int LVL_BITS         = $clog2(DEPTH + 1),
  localparam int W               = 8 * DATA_WIDTH_BYTES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start_read,
  input  logic                i_stop_read,
  input  logic                i_read_next,
  output logic [W-1:0]        o_data_out,
  output logic                o_data_ready,
  output logic [LVL_BITS-1:0] o_level,
  output logic                o_underrun,
  input  logic                i_clr_underrun,
  output logic                o_spi_start_read,
  output logic                o_spi_continue_read,
  output logic                o_spi_stop_read,
  input  logic                i_spi_busy,
  input  logic [W-1:0]        i_spi_data
);

  localparam int AW = $clog2(DEPTH);

  state_e              r_state, w_state_nxt;
  logic                r_pending, w_pending_nxt;
  logic                r_cont, w_cont_nxt;
  logic                r_unr;
  logic [AW-1:0]       r_wptr, r_rptr;
  logic [LVL_BITS-1:0] r_level, w_level_nxt;
  logic                w_streaming, w_flush, w_ready, w_pop, w_cap, w_we;

  assign w_streaming = (r_state == ST_STREAM);
  assign w_flush     = i_start_read | i_stop_read;
  assign w_ready     = (r_level != '0);
  assign w_pop       = i_read_next & w_ready;
  // While the continue pulse is on the wire the controller has not raised busy yet.
  assign w_cap       = r_pending & ~r_cont & ~i_spi_busy;
  assign w_we        = w_cap & ~w_flush;
  assign w_level_nxt = r_level + LVL_BITS'(w_cap) - LVL_BITS'(w_pop);

  always_comb begin
    w_state_nxt      = r_state;
    w_pending_nxt    = r_pending;
    w_cont_nxt       = 1'b0;
    o_spi_start_read = 1'b0;
    o_spi_stop_read  = 1'b0;
    if (i_stop_read) begin
      w_state_nxt     = ST_IDLE;
      w_pending_nxt   = 1'b0;
      o_spi_stop_read = w_streaming;
    end else if (i_start_read) begin
      w_state_nxt      = ST_STREAM;
      w_pending_nxt    = 1'b1;
      o_spi_start_read = 1'b1;
    end else begin
      if (w_cap) w_pending_nxt = 1'b0;
      // Space check includes this cycle's capture, so the next word always has a slot.
      if (w_streaming && (!r_pending || w_cap) && (w_level_nxt < LVL_BITS'(DEPTH))) begin
        w_cont_nxt    = 1'b1;
        w_pending_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
      r_cont    <= 1'b0;
      r_unr     <= 1'b0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      r_cont    <= w_cont_nxt;
      if (i_read_next && !w_ready && w_streaming) r_unr <= 1'b1;
      else if (i_clr_underrun)                    r_unr <= 1'b0;
      if (w_flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_level <= '0;
      end else begin
        if (w_cap) r_wptr <= r_wptr + AW'(1);
        if (w_pop) r_rptr <= r_rptr + AW'(1);
        r_level <= w_level_nxt;
      end
    end
  end

  qspi_stream_fifo_mem #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wptr),
    .i_wdata (i_spi_data),
    .i_raddr (r_rptr),
    .o_rdata (o_data_out)
  );

  assign o_data_ready        = w_ready;
  assign o_level             = r_level;
  assign o_underrun          = r_unr;
  assign o_spi_continue_read = r_cont;

endmodule

// File: tb/tb_qspi_stream_fifo.sv
// Bench for qspi_stream_fifo: DEPTH=4 and DEPTH=8 instances on shared stimulus, each with its own
// controller model, checked every cycle against a queue-based reference plus literal expectations.
module tb_qspi_stream_fifo;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start_read, stop_read, read_next, clr_unr, cmp_en;
  logic [W-1:0] dout0, dout1;
  logic rdy0, rdy1, unr0, unr1, st0, st1, co0, co1, sp0, sp1;
  logic [2:0] lvl0;
  logic [3:0] lvl1;

  logic         busy  [2];
  logic [W-1:0] sdata [2];
  int           cnt   [2];
  logic [W-1:0] addr  [2];

  logic         a_rdy [2], a_unr [2], a_st [2], a_co [2], a_sp [2];
  logic [W-1:0] a_dout[2];
  logic [3:0]   a_lvl [2];

  int n_cmp = 0, n_err = 0;
  int n_st [2], n_co [2];
  logic [W-1:0] popped [2][$];

  // reference model state
  logic [W-1:0] mq [2][$];
  bit m_str [2], m_fetch [2], m_cont [2], m_unr [2];

  qspi_stream_fifo #(.DATA_WIDTH_BYTES(2), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .i_start_read(start_read), .i_stop_read(stop_read),
    .i_read_next(read_next), .o_data_out(dout0), .o_data_ready(rdy0), .o_level(lvl0),
    .o_underrun(unr0), .i_clr_underrun(clr_unr), .o_spi_start_read(st0),
    .o_spi_continue_read(co0), .o_spi_stop_read(sp0), .i_spi_busy(busy[0]), .i_spi_data(sdata[0])
  );

  qspi_stream_fifo #(.DATA_WIDTH_BYTES(2), .DEPTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .i_start_read(start_read), .i_stop_read(stop_read),
    .i_read_next(read_next), .o_data_out(dout1), .o_data_ready(rdy1), .o_level(lvl1),
    .o_underrun(unr1), .i_clr_underrun(clr_unr), .o_spi_start_read(st1),
    .o_spi_continue_read(co1), .o_spi_stop_read(sp1), .i_spi_busy(busy[1]), .i_spi_data(sdata[1])
  );

  always_comb begin
    a_rdy[0] = rdy0;  a_rdy[1] = rdy1;
    a_unr[0] = unr0;  a_unr[1] = unr1;
    a_st[0]  = st0;   a_st[1]  = st1;
    a_co[0]  = co0;   a_co[1]  = co1;
    a_sp[0]  = sp0;   a_sp[1]  = sp1;
    a_dout[0] = dout0; a_dout[1] = dout1;
    a_lvl[0] = {1'b0, lvl0}; a_lvl[1] = lvl1;
  end

  // Controller: busy rises the cycle after start/continue, drops after 6 cycles with data=addr++.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        busy[d] <= 1'b0; cnt[d] <= 0; addr[d] <= '0; sdata[d] <= '0;
      end else if (a_sp[d]) begin
        busy[d] <= 1'b0; cnt[d] <= 0;
      end else if (a_st[d]) begin
        busy[d] <= 1'b1; cnt[d] <= 6; addr[d] <= '0;
      end else if (a_co[d]) begin
        busy[d] <= 1'b1; cnt[d] <= 6;
      end else if (busy[d]) begin
        cnt[d] <= cnt[d] - 1;
        if (cnt[d] == 1) begin
          busy[d] <= 1'b0; sdata[d] <= addr[d]; addr[d] <= addr[d] + 16'd1;
        end
      end
    end
  end

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0h want %0h", nm, d, act, exp);
    end
  endtask

  // Per-cycle compare, then advance the model with this cycle's inputs.
  initial begin
    int dep;
    bit cap, popv;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        for (int d = 0; d < 2; d++) begin
          chk("level", d, 32'(a_lvl[d]), 32'(mq[d].size()));
          chk("ready", d, 32'(a_rdy[d]), 32'(mq[d].size() != 0));
          if (mq[d].size() != 0) chk("data", d, 32'(a_dout[d]), 32'(mq[d][0]));
          chk("underrun", d, 32'(a_unr[d]), 32'(m_unr[d]));
          chk("spi_start", d, 32'(a_st[d]), 32'(start_read && !stop_read));
          chk("spi_cont", d, 32'(a_co[d]), 32'(m_cont[d]));
          chk("spi_stop", d, 32'(a_sp[d]), 32'(stop_read && m_str[d]));
        end
      end
      for (int d = 0; d < 2; d++) begin
        dep = (d == 0) ? 4 : 8;
        if (!rst_n) begin
          mq[d].delete(); m_str[d] = 0; m_fetch[d] = 0; m_cont[d] = 0; m_unr[d] = 0;
        end else begin
          cap  = m_fetch[d] && !m_cont[d] && !busy[d];
          popv = read_next && (mq[d].size() != 0);
          if (read_next && mq[d].size() == 0 && m_str[d]) m_unr[d] = 1;
          else if (clr_unr) m_unr[d] = 0;
          m_cont[d] = 0;
          if (stop_read) begin
            m_str[d] = 0; m_fetch[d] = 0; mq[d].delete();
          end else if (start_read) begin
            m_str[d] = 1; m_fetch[d] = 1; mq[d].delete();
          end else begin
            if (popv) void'(mq[d].pop_front());
            if (cap) begin mq[d].push_back(sdata[d]); m_fetch[d] = 0; end
            if (m_str[d] && !m_fetch[d] && mq[d].size() < dep) begin
              m_cont[d] = 1; m_fetch[d] = 1;
            end
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (a_st[d]) n_st[d]++;
        if (a_co[d]) n_co[d]++;
        if (read_next && a_rdy[d]) popped[d].push_back(a_dout[d]);
      end
      @(posedge clk); #1;
      start_read = 1'b0; stop_read = 1'b0; clr_unr = 1'b0;
    end
  endtask

  task automatic wait_lvl(input int v);
    int k = 0;
    while (a_lvl[0] != 4'(v) && k < 50) begin cyc(1); k++; end
    chk("wait_level", 0, 32'(a_lvl[0]), 32'(v));
  endtask

  task automatic wait_busy(input logic v);
    int k = 0;
    while (busy[0] !== v && k < 30) begin cyc(1); k++; end
    chk("wait_busy", 0, 32'(busy[0]), 32'(v));
  endtask

  task automatic wait_rdy();
    int k = 0;
    while (a_rdy[0] !== 1'b1 && k < 30) begin cyc(1); k++; end
    chk("wait_ready", 0, 32'(a_rdy[0]), 32'd1);
  endtask

  // Fill from empty with no pops, then pop every cycle through a drain.
  task automatic fill_drain();
    for (int d = 0; d < 2; d++) begin n_st[d] = 0; n_co[d] = 0; popped[d].delete(); end
    start_read = 1'b1;
    cyc(75);
    chk("fill_level", 0, 32'(a_lvl[0]), 32'd4);
    chk("fill_level", 1, 32'(a_lvl[1]), 32'd8);
    chk("fill_fetches", 0, 32'(n_st[0] + n_co[0]), 32'd4);
    chk("fill_fetches", 1, 32'(n_st[1] + n_co[1]), 32'd8);
    chk("fill_head", 0, 32'(a_dout[0]), 32'h0);
    chk("fill_head", 1, 32'(a_dout[1]), 32'h0);
    read_next = 1'b1;
    cyc(40);
    read_next = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("drain_count", d, 32'(popped[d].size() > ((d == 0) ? 4 : 8)), 32'd1);
      for (int i = 0; i < popped[d].size(); i++) chk("drain_order", d, 32'(popped[d][i]), 32'(i));
    end
    chk("drain_underrun", 0, 32'(a_unr[0]), 32'd1);
    chk("drain_underrun", 1, 32'(a_unr[1]), 32'd1);
    clr_unr = 1'b1;
    cyc(1);
    chk("clr_underrun", 0, 32'(a_unr[0]), 32'd0);
    chk("clr_underrun", 1, 32'(a_unr[1]), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start_read = 1'b0; stop_read = 1'b0; read_next = 1'b0; clr_unr = 1'b0;
    cmp_en = 1'b0;
    @(posedge clk); #1;
    cmp_en = 1'b1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_level", d, 32'(a_lvl[d]), 32'd0);
      chk("rst_ready", d, 32'(a_rdy[d]), 32'd0);
      chk("rst_cont", d, 32'(a_co[d]), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    fill_drain();

    // pop in the capture cycle with one entry held
    start_read = 1'b1;
    cyc(1);
    wait_lvl(1);
    wait_busy(1'b1);
    wait_busy(1'b0);
    read_next = 1'b1;
    cyc(1);
    read_next = 1'b0;
    chk("popcap_ready", 0, 32'(a_rdy[0]), 32'd1);
    chk("popcap_data", 0, 32'(a_dout[0]), 32'h1);
    chk("popcap_level", 0, 32'(a_lvl[0]), 32'd1);

    // stop while a fetch is in flight
    wait_busy(1'b1);
    stop_read = 1'b1;
    @(negedge clk);
    chk("stop_pulse", 0, 32'(a_sp[0]), 32'd1);
    chk("stop_pulse", 1, 32'(a_sp[1]), 32'd1);
    @(posedge clk); #1;
    stop_read = 1'b0;
    chk("stop_level", 0, 32'(a_lvl[0]), 32'd0);
    cyc(25);
    chk("stop_no_late", 0, 32'(a_rdy[0]), 32'd0);
    chk("stop_no_late", 1, 32'(a_lvl[1]), 32'd0);

    // restart mid-stream at level 3
    start_read = 1'b1;
    cyc(1);
    wait_lvl(3);
    n_st[0] = 0;
    start_read = 1'b1;
    @(negedge clk);
    chk("restart_pulse", 0, 32'(a_st[0]), 32'd1);
    @(posedge clk); #1;
    start_read = 1'b0;
    chk("restart_flush", 0, 32'(a_lvl[0]), 32'd0);
    wait_rdy();
    chk("restart_first", 0, 32'(a_dout[0]), 32'h0);
    chk("restart_single", 0, 32'(n_st[0]), 32'd0);

    // reset mid-fetch with underrun set
    start_read = 1'b1;
    cyc(1);
    read_next = 1'b1;
    cyc(1);
    read_next = 1'b0;
    chk("pre_rst_underrun", 0, 32'(a_unr[0]), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      chk("midrst_level", d, 32'(a_lvl[d]), 32'd0);
      chk("midrst_ready", d, 32'(a_rdy[d]), 32'd0);
      chk("midrst_underrun", d, 32'(a_unr[d]), 32'd0);
      chk("midrst_spi", d, 32'({a_st[d], a_co[d], a_sp[d]}), 32'd0);
    end
    rst_n = 1'b1;

    fill_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
